// File: rtl/fetch_pc_unit.sv
// Small synchronous FIFO with flush; flush overrides push and pop in the same cycle.
// Latency: a pushed entry is visible at the head after the push edge.
// Backpressure: the caller must not push when full or pop when empty.
module fetch_fifo #(
    parameter int W     = 96,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

// PC register and single-outstanding instruction fetch feeding a 2-entry decode buffer.
// Latency: request accepted -> rvalid -> insn_valid after that edge; 1 insn per 2 cycles at best.
// Backpressure: no new request while the buffer holds 2 entries; insn_ready pops the head.
module fetch_pc_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_valid,
    input  logic            pc_alu_sel,
    input  logic [XLEN-1:0] alu_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            insn_valid,
    output logic [31:0]     insn,
    output logic [XLEN-1:0] insn_pc,
    input  logic            insn_ready
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    typedef struct packed {
        logic [31:0]     insn;
        logic [XLEN-1:0] pc;
    } ent_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic [1:0]      count;
    logic            redirect;
    logic            fire;
    logic            push;
    logic            pop;
    ent_t            push_ent;
    ent_t            head_ent;

    assign redirect = br_valid & pc_alu_sel;
    assign imem_req = (state == REQ) & (count < 2'd2) & ~redirect;
    assign imem_addr = pc;
    assign fire     = imem_req & imem_ready;
    // Responses for a flushed request land in DROP, never here, so only WAIT pushes.
    assign push     = (state == WAIT) & imem_rvalid & ~redirect;
    assign pop      = insn_valid & insn_ready;
    assign push_ent = '{insn: imem_rdata, pc: req_pc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            if (redirect) begin
                pc <= alu_target & ~XLEN'(3);
            end else if (fire) begin
                pc     <= pc + XLEN'(4);
                req_pc <= pc;
            end
            case (state)
                IDLE:    state <= REQ;
                REQ:     if (fire) state <= WAIT;
                WAIT:    if (imem_rvalid) state <= REQ;
                         else if (redirect) state <= DROP;
                DROP:    if (imem_rvalid) state <= REQ;
                default: state <= IDLE;
            endcase
        end
    end

    fetch_fifo #(.W($bits(ent_t)), .DEPTH(2)) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .head_dat (head_ent),
        .count    (count)
    );

    assign insn_valid = (count != 2'd0);
    assign insn       = head_ent.insn;
    assign insn_pc    = head_ent.pc;
endmodule
